// File: rtl/seg_scan_engine.sv
// Multiplexed 7-segment scan engine with double-buffered glyph memory, blink and PWM dimming.
// Optional lamp test is compiled in with `define SEG_LAMP_TEST_EN.
module seg_scan_engine #(
  parameter int unsigned NUM_DIGITS       = 8,
  parameter int unsigned DIGITS_PER_GROUP = 4,
  parameter int unsigned SCAN_DIV         = 8192,
  parameter int unsigned BLINK_FRAMES     = 64,
  parameter bit          CS_ACTIVE_LOW    = 1'b0,
  parameter bit          SEG_ACTIVE_LOW   = 1'b0,
  localparam int unsigned NUM_GROUPS      = NUM_DIGITS / DIGITS_PER_GROUP,
  localparam int unsigned AW              = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic                    wr_raw,
  input  logic [7:0]              wr_data,
  input  logic                    commit,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [2:0]              brightness,
  input  logic                    lamp_test,
  output logic                    commit_pending,
  output logic                    frame_start,
  output logic [NUM_DIGITS-1:0]   seg_cs,
  output logic [8*NUM_GROUPS-1:0] seg_data
);

  localparam int unsigned SUB_DIV = SCAN_DIV / 8;
  localparam int unsigned SW      = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam int unsigned FW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned DW      = 8 * NUM_GROUPS;

  localparam logic [NUM_DIGITS-1:0] CS_INACTIVE  = {NUM_DIGITS{CS_ACTIVE_LOW}};
  localparam logic [DW-1:0]         SEG_INACTIVE = {DW{SEG_ACTIVE_LOW}};

  // Active-high {g,f,e,d,c,b,a} pattern for a hex nibble
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  // slot_cnt is held split as {pwm phase, sub-slot count} so the PWM phase needs no divider
  logic [SW-1:0]         sub_cnt_q, sub_cnt_d;
  logic [2:0]            phase_q, phase_d;
  logic [AW-1:0]         digit_idx_q, digit_idx_d;
  logic [FW-1:0]         frame_cnt_q, frame_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic                  commit_pending_q, commit_pending_d;
  logic                  frame_wrap_q, frame_wrap_d;
  logic                  frame_start_q, frame_start_d;
  logic [7:0]            shadow_q [NUM_DIGITS];
  logic [7:0]            shadow_d [NUM_DIGITS];
  logic [7:0]            active_q [NUM_DIGITS];
  logic [7:0]            active_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] seg_cs_q, seg_cs_d;
  logic [DW-1:0]         seg_data_q, seg_data_d;

  logic                  sub_end, slot_end, digit_end, frame_end, blink_end, do_copy;
  logic [7:0]            wr_glyph;
  logic [7:0]            glyph, seg_val;
  logic                  lit;
  logic [NUM_DIGITS-1:0] cs_raw;
  logic [DW-1:0]         data_raw;

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_cnt_q        <= '0;
      phase_q          <= '0;
      digit_idx_q      <= '0;
      frame_cnt_q      <= '0;
      blink_phase_q    <= 1'b0;
      commit_pending_q <= 1'b0;
      frame_wrap_q     <= 1'b0;
      frame_start_q    <= 1'b0;
      shadow_q         <= '{default: '0};
      active_q         <= '{default: '0};
      seg_cs_q         <= CS_INACTIVE;
      seg_data_q       <= SEG_INACTIVE;
    end else begin
      sub_cnt_q        <= sub_cnt_d;
      phase_q          <= phase_d;
      digit_idx_q      <= digit_idx_d;
      frame_cnt_q      <= frame_cnt_d;
      blink_phase_q    <= blink_phase_d;
      commit_pending_q <= commit_pending_d;
      frame_wrap_q     <= frame_wrap_d;
      frame_start_q    <= frame_start_d;
      shadow_q         <= shadow_d;
      active_q         <= active_d;
      seg_cs_q         <= seg_cs_d;
      seg_data_q       <= seg_data_d;
    end
  end

  // Scan counters, buffer writes and frame-boundary commit
  always_comb begin
    sub_cnt_d        = sub_cnt_q;
    phase_d          = phase_q;
    digit_idx_d      = digit_idx_q;
    frame_cnt_d      = frame_cnt_q;
    blink_phase_d    = blink_phase_q;
    commit_pending_d = commit_pending_q;
    shadow_d         = shadow_q;
    active_d         = active_q;

    sub_end   = (32'(sub_cnt_q) == SUB_DIV - 1);
    slot_end  = sub_end && (phase_q == 3'd7);
    digit_end = (digit_idx_q == AW'(NUM_DIGITS - 1));
    frame_end = slot_end && digit_end;
    blink_end = (frame_cnt_q == FW'(BLINK_FRAMES - 1));
    do_copy   = frame_end && (commit_pending_q || commit);

    frame_wrap_d = frame_end;

    if (sub_end) begin
      sub_cnt_d = '0;
      phase_d   = phase_q + 3'd1;
    end else begin
      sub_cnt_d = sub_cnt_q + SW'(1);
    end

    if (slot_end) begin
      digit_idx_d = digit_end ? '0 : digit_idx_q + AW'(1);
    end

    if (frame_end) begin
      if (blink_end) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end

    // Copy samples shadow_q, so a same-cycle write lands only in the shadow
    if (do_copy) begin
      active_d         = shadow_q;
      commit_pending_d = 1'b0;
    end else if (commit) begin
      commit_pending_d = 1'b1;
    end

    wr_glyph = wr_raw ? wr_data : {wr_data[7], hex_glyph(wr_data[3:0])};
    if (wr_en && (32'(wr_addr) < NUM_DIGITS)) begin
      shadow_d[wr_addr] = wr_glyph;
    end
  end

  // Registered display outputs, one cycle behind the scan counters
  always_comb begin
    glyph   = active_q[digit_idx_q];
    lit     = (phase_q <= brightness);
    seg_val = (blink_phase_q && blink_mask[digit_idx_q]) ? 8'h00 : glyph;
`ifdef SEG_LAMP_TEST_EN
    if (lamp_test) begin
      lit     = 1'b1;
      seg_val = 8'hFF;
    end
`endif
    cs_raw   = '0;
    data_raw = '0;
    if (lit) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (digit_idx_q == AW'(i)) begin
          cs_raw[i]                                 = 1'b1;
          data_raw[8*(i/DIGITS_PER_GROUP) +: 8]     = seg_val;
        end
      end
    end
    seg_cs_d      = cs_raw ^ CS_INACTIVE;
    seg_data_d    = data_raw ^ SEG_INACTIVE;
    frame_start_d = frame_wrap_q;
  end

`ifndef SEG_LAMP_TEST_EN
  logic unused_lamp_test;
  assign unused_lamp_test = lamp_test;
`endif

  assign commit_pending = commit_pending_q;
  assign frame_start    = frame_start_q;
  assign seg_cs         = seg_cs_q;
  assign seg_data       = seg_data_q;

endmodule

// File: tb/tb_seg_scan_engine.sv
// Self-checking bench for seg_scan_engine: cycle-count reference model feeding a scoreboard queue,
// plus directed checks of commit timing, PWM duty, blink and lamp test.
module tb_seg_scan_engine;

  localparam int unsigned ND  = 8;
  localparam int unsigned DPG = 4;
  localparam int unsigned SD  = 16;
  localparam int unsigned BF  = 2;
  localparam int unsigned FRAME = SD * ND;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic        wr_raw;
  logic [7:0]  wr_data;
  logic        commit;
  logic [7:0]  blink_mask;
  logic [2:0]  brightness;
  logic        lamp_test;
  logic        commit_pending;
  logic        frame_start;
  logic [7:0]  seg_cs;
  logic [15:0] seg_data;

  int tests = 0;
  int fails = 0;

  seg_scan_engine #(
    .NUM_DIGITS(ND), .DIGITS_PER_GROUP(DPG), .SCAN_DIV(SD), .BLINK_FRAMES(BF),
    .CS_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_raw(wr_raw),
    .wr_data(wr_data), .commit(commit), .blink_mask(blink_mask), .brightness(brightness),
    .lamp_test(lamp_test), .commit_pending(commit_pending), .frame_start(frame_start),
    .seg_cs(seg_cs), .seg_data(seg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: counters derived from cycles since reset release
  typedef struct packed {
    logic [7:0]  cs;
    logic [15:0] data;
    logic        fs;
    logic        pend;
  } exp_t;

  exp_t        sb[$];
  logic [6:0]  hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [7:0]  m_shadow [ND];
  logic [7:0]  m_active [ND];
  logic        m_pend;
  int          m_cyc;

  task automatic model_reset();
    for (int i = 0; i < ND; i++) begin
      m_shadow[i] = 8'h00;
      m_active[i] = 8'h00;
    end
    m_pend = 1'b0;
    m_cyc  = 0;
    sb.delete();
  endtask

  task automatic model_step();
    exp_t e;
    int   slot, digit, frame;
    logic lamp, lit, bph;
    logic [7:0] val;
    slot  = m_cyc % SD;
    digit = (m_cyc / SD) % ND;
    frame = m_cyc / FRAME;
    bph   = ((frame / BF) % 2) == 1;
`ifdef SEG_LAMP_TEST_EN
    lamp = lamp_test;
`else
    lamp = 1'b0;
`endif
    lit    = lamp || ((slot / (SD / 8)) <= int'(brightness));
    e.cs   = '0;
    e.data = '0;
    if (lit) begin
      val = lamp ? 8'hFF : ((bph && blink_mask[digit]) ? 8'h00 : m_active[digit]);
      e.cs[digit] = 1'b1;
      e.data[8*(digit/DPG) +: 8] = val;
    end
    e.fs = (m_cyc % FRAME == 0) && (m_cyc != 0);
    if ((m_cyc % FRAME == FRAME - 1) && (m_pend || commit)) begin
      for (int i = 0; i < ND; i++) m_active[i] = m_shadow[i];
      m_pend = 1'b0;
    end else if (commit) begin
      m_pend = 1'b1;
    end
    if (wr_en && wr_addr < ND)
      m_shadow[wr_addr] = wr_raw ? wr_data : {wr_data[7], hex_tab[wr_data[3:0]]};
    e.pend = m_pend;
    m_cyc++;
    sb.push_back(e);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_seg_cs", 32'(seg_cs), 32'(e.cs));
      chk("sb_seg_data", 32'(seg_data), 32'(e.data));
      chk("sb_frame_start", 32'(frame_start), 32'(e.fs));
      chk("sb_commit_pending", 32'(commit_pending), 32'(e.pend));
    end
  end

  // Advance to the next frame_start (bounded); returns negedges waited
  task automatic wait_fs(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 3 * FRAME);
    chk("frame_start_seen", 32'(frame_start), 32'd1);
  endtask

  task automatic count_lit(output int cs_cnt, output int ff_cnt);
    cs_cnt = 0;
    ff_cnt = 0;
    for (int i = 0; i < SD; i++) begin
      if (seg_cs == 8'h01) cs_cnt++;
      if (seg_data[7:0] == 8'hFF) ff_cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n, cs_cnt, ff_cnt, on_cnt;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_raw = 1'b0; wr_data = '0;
    commit = 1'b0; blink_mask = '0; brightness = 3'd7; lamp_test = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_seg_cs", 32'(seg_cs), 32'h0);
    chk("rst_seg_data", 32'(seg_data), 32'h0);
    chk("rst_commit_pending", 32'(commit_pending), 32'h0);
    chk("rst_frame_start", 32'(frame_start), 32'h0);
    rst_n = 1'b1;

    wait_fs(n);
    chk("first_fs_cycle", 32'(n), 32'(FRAME + 1));
    chk("blank_before_commit", 32'(seg_data), 32'h0);

    // Hex writes then a mid-frame commit
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h08;
    @(negedge clk);
    wr_addr = 3'd5; wr_data = 8'h8A;
    @(negedge clk);
    wr_en = 1'b0; commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    chk("pending_after_commit", 32'(commit_pending), 32'h1);
    wait_fs(n);
    chk("pending_cleared", 32'(commit_pending), 32'h0);
    chk("d0_cs", 32'(seg_cs), 32'h01);
    chk("d0_data", 32'(seg_data), 32'h007F);
    repeat (5 * SD) @(negedge clk);
    chk("d5_cs", 32'(seg_cs), 32'h20);
    chk("d5_data", 32'(seg_data), 32'hF700);

    // Raw write on the boundary cycle with a commit pending
    wait_fs(n);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    repeat (FRAME - 3) @(negedge clk);
    wr_en = 1'b1; wr_raw = 1'b1; wr_addr = 3'd0; wr_data = 8'h06;
    @(negedge clk);
    wr_en = 1'b0; wr_raw = 1'b0;
    wait_fs(n);
    chk("boundary_write_kept_old", 32'(seg_data), 32'h007F);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    wait_fs(n);
    chk("second_commit_shows_06", 32'(seg_data), 32'h0006);

    // PWM duty per slot
    brightness = 3'd0;
    wait_fs(n);
    count_lit(cs_cnt, ff_cnt);
    chk("duty_b0", 32'(cs_cnt), 32'd2);
    brightness = 3'd7;
    wait_fs(n);
    count_lit(cs_cnt, ff_cnt);
    chk("duty_b7", 32'(cs_cnt), 32'd16);
    brightness = 3'd3;
    wait_fs(n);
    count_lit(cs_cnt, ff_cnt);
    chk("duty_b3", 32'(cs_cnt), 32'd8);

    // Blink digit 0 over four frames
    brightness = 3'd7; blink_mask = 8'h01;
    cs_cnt = 0; on_cnt = 0;
    for (int f = 0; f < 4; f++) begin
      wait_fs(n);
      if (seg_cs == 8'h01) cs_cnt++;
      if (seg_data[7:0] == 8'h06) on_cnt++;
    end
    chk("blink_cs_steady", 32'(cs_cnt), 32'd4);
    chk("blink_on_frames", 32'(on_cnt), 32'd2);

    // Lamp test with dim brightness and blink on every digit
    lamp_test = 1'b1; brightness = 3'd0; blink_mask = 8'hFF;
    wait_fs(n);
    count_lit(cs_cnt, ff_cnt);
`ifdef SEG_LAMP_TEST_EN
    chk("lamp_cs", 32'(cs_cnt), 32'd16);
    chk("lamp_ff", 32'(ff_cnt), 32'd16);
`else
    chk("lamp_cs", 32'(cs_cnt), 32'd2);
    chk("lamp_ff", 32'(ff_cnt), 32'd0);
`endif
    repeat (FRAME) @(negedge clk);

    // Reset in the middle of a pending commit
    lamp_test = 1'b0; blink_mask = '0; brightness = 3'd7;
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'h01;
    @(negedge clk);
    wr_en = 1'b0; commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    chk("pending_before_reset", 32'(commit_pending), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_pending", 32'(commit_pending), 32'h0);
    chk("abort_seg_cs", 32'(seg_cs), 32'h0);
    chk("abort_seg_data", 32'(seg_data), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_fs(n);
    chk("reset_fs_cycle", 32'(n), 32'(FRAME + 1));
    chk("reset_blank_d0", 32'(seg_data), 32'h0);
    chk("reset_cs_d0", 32'(seg_cs), 32'h01);
    repeat (3 * SD + 2) @(negedge clk);
    chk("reset_blank_d3", 32'(seg_data), 32'h0);
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg_scan_engine.md
Name: seg_scan_engine

Overview:
- Parametrised multiplexed 7-segment scan engine.
- Owns a double-buffered frame memory: the FSM/display layer writes glyphs into a shadow buffer and commits them; the scanner swaps buffers only at a frame boundary, so the display never tears.
- Adds hex/raw glyph writes, per-digit blink, PWM brightness and configurable polarity.
- Drives the board digit selects and one segment bus per digit group.

Parameters:
- NUM_DIGITS, 8, total digits scanned; digit 0 is leftmost.
- DIGITS_PER_GROUP, 4, digits sharing one segment bus; NUM_GROUPS = NUM_DIGITS/DIGITS_PER_GROUP.
- SCAN_DIV, 8192, clk cycles per digit slot; must be a multiple of 8 and at least 8.
- BLINK_FRAMES, 64, full frames per blink half-period.
- CS_ACTIVE_LOW, 0, 1 inverts seg_cs.
- SEG_ACTIVE_LOW, 0, 1 inverts seg_data.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_en  in  1  write a shadow-buffer entry this cycle.
- wr_addr  in  AW=$clog2(NUM_DIGITS)  digit index; writes with wr_addr >= NUM_DIGITS are ignored.
- wr_raw  in  1  1: wr_data is a raw {dp,g,f,e,d,c,b,a} pattern; 0: hex mode.
- wr_data  in  8  in hex mode, [3:0] selects glyph 0-F and [7] is the dp.
- commit  in  1  pulse that requests shadow→active copy at the next frame boundary.
- blink_mask  in  NUM_DIGITS  bit i set makes digit i blink.
- brightness  in  3  0 = 1/8 duty … 7 = full duty.
- lamp_test  in  1  see Optional Feature.
- commit_pending  out  1  commit requested but not yet applied.
- frame_start  out  1  one-cycle pulse when the scan wraps to digit 0.
- seg_cs  out  NUM_DIGITS  one-hot digit select.
- seg_data  out  8*NUM_GROUPS  group g occupies bits [8g+7:8g].

Behaviour:
- Reset state:
  - Shadow and active buffers are all 8'h00.
  - slot_cnt, digit_idx, frame_cnt, blink_phase, commit_pending and frame_start are all 0.
  - seg_cs and seg_data are at their inactive level: all 0 when not inverted, all 1 when inverted.
  - Reset mid-frame or mid-commit aborts immediately; no partial copy survives.
- Hex decode is active-high {dp,g,f,e,d,c,b,a}: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. dp ORs in bit 7.
- The decoded value is stored in the shadow buffer on the wr_en cycle.
- Scan counters:
  - slot_cnt runs 0..SCAN_DIV-1. On wrap, digit_idx increments.
  - digit_idx wraps from NUM_DIGITS-1 to 0.
  - On the digit_idx wrap, frame_cnt increments; when it reaches BLINK_FRAMES-1 it resets and blink_phase toggles.
- Frame boundary is the cycle where slot_cnt = SCAN_DIV-1 and digit_idx = NUM_DIGITS-1.
  - If commit_pending, or commit is high in that same cycle, all shadow entries copy to active and commit_pending clears.
  - A wr_en in the same cycle writes the shadow, but the copy uses the pre-write shadow contents.
- commit_pending rules:
  - Set the cycle after a commit that is not at a boundary.
  - Repeated commits while pending are idempotent.
- frame_start is registered: high for exactly the first cycle of digit 0's slot.
- PWM: phase = slot_cnt / (SCAN_DIV/8). The digit is lit iff phase <= brightness.
- Output, registered, 1-cycle latency from the counters:
  - When lit: seg_cs = one-hot(digit_idx).
  - Group g = digit_idx / DIGITS_PER_GROUP drives active[digit_idx]; all other groups drive 8'h00.
  - When unlit: seg_cs and all groups drive 0.
  - Blink: if blink_phase = 1 and blink_mask[digit_idx] = 1, segments are 8'h00 while seg_cs still follows PWM.
  - Polarity inversion is applied last.
- The buffers are NUM_DIGITS x 8 registers; no RAM inference is required.

Optional Feature:
- SEG_LAMP_TEST_EN defined: when lamp_test = 1, every lit slot drives segments 8'hFF (polarity applied).
  - Blink and brightness are ignored: full duty, and seg_cs still scans.
  - Buffers and commit logic are unaffected.
- SEG_LAMP_TEST_EN undefined: lamp_test is ignored and no logic is generated for it.

Test Plan (SCAN_DIV=16, BLINK_FRAMES=2, NUM_DIGITS=8, DIGITS_PER_GROUP=4, non-inverted):
- Reset → seg_cs=00, seg_data=0000, commit_pending=0. After release, the first frame_start comes 1 cycle after the first frame wrap (cycle 128 + 1). All data are blank before any commit.
- Hex write: addr 0 = 0x8, addr 5 = 0x8A (dp+A), then commit mid-frame.
  - commit_pending=1 until the boundary.
  - Next frame: digit 0 slot gives seg_cs=01, seg_data[7:0]=7F, group1=00.
  - Digit 5 slot gives seg_cs=20, seg_data[15:8]=F7, group0=00.
- Write at the boundary cycle: addr 0 = raw 0x06 on the same cycle as the boundary with a commit pending.
  - Active[0] keeps its old value.
  - A second commit makes digit 0 show 06 from the following frame.
- Brightness 0 → digit lit for slot_cnt 0-1 only (2 cycles of 16). Brightness 7 → lit all 16 cycles. Brightness 3 → lit 8 cycles.
- blink_mask=0x01, brightness 7 → digit 0 segments alternate 2 frames on / 2 frames off, with seg_cs=01 throughout; the other digits are steady.
- Lamp test:
  - With SEG_LAMP_TEST_EN and lamp_test=1, brightness 0, blink active: every slot shows seg_data group = FF for all 16 cycles.
  - Without the macro: output identical to lamp_test=0.
